// File: rtl/spike_window_counter.sv
// Per-channel spike counter over a programmable window of enabled cycles, with a registered report.
// Optional winner-take-all index/valid when SPIKE_WTA_EN is defined; otherwise both are tied to 0.
module spike_window_counter #(
  parameter int unsigned N_CH  = 3,
  parameter int unsigned CNT_W = 8,
  parameter int unsigned WIN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    start,
  input  logic [WIN_W-1:0]        window_len,
  input  logic [N_CH-1:0]         spike_in,
  output logic [N_CH*CNT_W-1:0]   count_out,
  output logic [1:0]              winner,
  output logic                    winner_valid,
  output logic                    valid,
  output logic                    busy,
  output logic                    overflow
);

  localparam int unsigned ACC_W = N_CH * CNT_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE, COUNT, REPORT} state_t;

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   timer, timer_nxt;
  logic [ACC_W-1:0]   cnt, cnt_nxt;
  logic               ovf, ovf_nxt;
  logic               latch_c;

  // Next-state, working counters and timer
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    cnt_nxt   = cnt;
    ovf_nxt   = ovf;
    latch_c   = 1'b0;
    case (state)
      IDLE, REPORT: begin
        state_nxt = IDLE;
        if (start && (window_len != '0)) begin
          state_nxt = COUNT;
          timer_nxt = window_len;
          cnt_nxt   = '0;
          ovf_nxt   = 1'b0;
        end
      end
      COUNT: begin
        if (enable) begin
          for (int i = 0; i < N_CH; i++) begin
            if (spike_in[i]) begin
              if (cnt[i*CNT_W +: CNT_W] == CNT_MAX) begin
                ovf_nxt = 1'b1;
              end else begin
                cnt_nxt[i*CNT_W +: CNT_W] = cnt[i*CNT_W +: CNT_W] + CNT_W'(1);
              end
            end
          end
          timer_nxt = timer - WIN_W'(1);
          if (timer == WIN_W'(1)) begin
            state_nxt = REPORT;
            latch_c   = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      valid     <= 1'b0;
      count_out <= '0;
      overflow  <= 1'b0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
      cnt   <= cnt_nxt;
      ovf   <= ovf_nxt;
      busy  <= (state_nxt == COUNT);
      valid <= (state_nxt == REPORT);
      if (latch_c) begin
        count_out <= cnt_nxt;
        overflow  <= ovf_nxt;
      end
    end
  end

`ifdef SPIKE_WTA_EN
  logic [1:0]       win_idx_c;
  logic [CNT_W-1:0] win_max_c;

  // Argmax over the counts being latched; strict > keeps the lowest index on ties
  always_comb begin
    win_idx_c = 2'd0;
    win_max_c = cnt_nxt[0 +: CNT_W];
    for (int i = 1; i < N_CH; i++) begin
      if (cnt_nxt[i*CNT_W +: CNT_W] > win_max_c) begin
        win_max_c = cnt_nxt[i*CNT_W +: CNT_W];
        win_idx_c = 2'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      winner       <= 2'd0;
      winner_valid <= 1'b0;
    end else if (latch_c) begin
      winner       <= win_idx_c;
      winner_valid <= |cnt_nxt;
    end
  end
`else
  assign winner       = 2'd0;
  assign winner_valid = 1'b0;
`endif

endmodule

// File: tb/tb_spike_window_counter.sv
// Randomised and directed bench for spike_window_counter against a window-level reference model.
module tb_spike_window_counter;

`ifdef SPIKE_WTA_EN
  localparam bit WTA = 1'b1;
`else
  localparam bit WTA = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  window_len = 8'd0;
  logic [2:0]  spike_in = 3'd0;

  logic [23:0] count8;
  logic [11:0] count4;
  logic [1:0]  win8, win4;
  logic        wv8, wv4, valid8, valid4, busy8, busy4, ovf8, ovf4;

  always #5 clk = ~clk;

  spike_window_counter #(.N_CH(3), .CNT_W(8), .WIN_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .window_len(window_len),
    .spike_in(spike_in), .count_out(count8), .winner(win8), .winner_valid(wv8),
    .valid(valid8), .busy(busy8), .overflow(ovf8));

  spike_window_counter #(.N_CH(3), .CNT_W(4), .WIN_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .start(start), .window_len(window_len),
    .spike_in(spike_in), .count_out(count4), .winner(win4), .winner_valid(wv4),
    .valid(valid4), .busy(busy4), .overflow(ovf4));

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: an open window accumulates unbounded raw sums; saturation applied at report
  bit          m_open;
  int          m_left;
  int          m_raw[3];
  bit          e_busy, e_valid, e_ovf8, e_ovf4, e_wv8, e_wv4;
  logic [23:0] e_cnt8;
  logic [11:0] e_cnt4;
  logic [1:0]  e_win8, e_win4;

  function automatic logic [1:0] argmax(input int s[3]);
    int b = 0;
    for (int i = 1; i < 3; i++) if (s[i] > s[b]) b = i;
    return 2'(b);
  endfunction

  task automatic publish();
    int s8[3];
    int s4[3];
    e_ovf8 = 1'b0;
    e_ovf4 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      s8[i] = (m_raw[i] > 255) ? 255 : m_raw[i];
      s4[i] = (m_raw[i] > 15) ? 15 : m_raw[i];
      if (m_raw[i] > 255) e_ovf8 = 1'b1;
      if (m_raw[i] > 15) e_ovf4 = 1'b1;
    end
    e_cnt8 = {8'(s8[2]), 8'(s8[1]), 8'(s8[0])};
    e_cnt4 = {4'(s4[2]), 4'(s4[1]), 4'(s4[0])};
    e_win8 = WTA ? argmax(s8) : 2'd0;
    e_win4 = WTA ? argmax(s4) : 2'd0;
    e_wv8  = WTA && ((s8[0] + s8[1] + s8[2]) != 0);
    e_wv4  = WTA && ((s4[0] + s4[1] + s4[2]) != 0);
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_open = 1'b0; m_left = 0; m_raw = '{default: 0};
      e_busy = 1'b0; e_valid = 1'b0; e_ovf8 = 1'b0; e_ovf4 = 1'b0;
      e_wv8 = 1'b0; e_wv4 = 1'b0; e_cnt8 = '0; e_cnt4 = '0; e_win8 = '0; e_win4 = '0;
    end else begin
      e_valid = 1'b0;
      if (m_open) begin
        if (enable) begin
          for (int i = 0; i < 3; i++) m_raw[i] += int'(spike_in[i]);
          m_left--;
          if (m_left == 0) begin
            m_open  = 1'b0;
            e_valid = 1'b1;
            publish();
          end
        end
      end else if (start && (window_len != 8'd0)) begin
        m_open = 1'b1;
        m_left = int'(window_len);
        m_raw  = '{default: 0};
      end
      e_busy = m_open;
    end
  end

  // Every-cycle comparison, away from the active edge
  initial forever begin
    @(negedge clk);
    check("busy8", 32'(busy8), 32'(e_busy));
    check("busy4", 32'(busy4), 32'(e_busy));
    check("valid8", 32'(valid8), 32'(e_valid));
    check("valid4", 32'(valid4), 32'(e_valid));
    check("count8", 32'(count8), 32'(e_cnt8));
    check("count4", 32'(count4), 32'(e_cnt4));
    check("ovf8", 32'(ovf8), 32'(e_ovf8));
    check("ovf4", 32'(ovf4), 32'(e_ovf4));
    check("win8", 32'(win8), 32'(e_win8));
    check("win4", 32'(win4), 32'(e_win4));
    check("wv8", 32'(wv8), 32'(e_wv8));
    check("wv4", 32'(wv4), 32'(e_wv4));
  end

  task automatic tick(input bit en, input bit st, input logic [7:0] len, input logic [2:0] sp);
    enable = en; start = st; window_len = len; spike_in = sp;
    @(negedge clk);
  endtask

  initial begin
    int v;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy8), 32'd0);
    check("rst_count", 32'(count8), 32'd0);
    rst_n = 1'b1;
    tick(0, 0, 8'd0, 3'd0);

    // Reset in the middle of an open window
    tick(1, 1, 8'd10, 3'b111);
    repeat (4) tick(1, 0, 8'd10, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(busy8), 32'd0);
    check("midrst_count", 32'(count8), 32'd0);
    check("midrst_valid", 32'(valid8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    v = 0;
    repeat (12) begin
      tick(1, 0, 8'd10, 3'b111);
      if (valid8) v++;
    end
    check("midrst_no_report", 32'(v), 32'd0);

    // Basic count: ch0 x5, ch1 x2, ch2 x0
    tick(1, 1, 8'd5, 3'b000);
    tick(1, 0, 8'd5, 3'b011);
    tick(1, 0, 8'd5, 3'b011);
    tick(1, 0, 8'd5, 3'b001);
    tick(1, 0, 8'd5, 3'b001);
    tick(1, 0, 8'd5, 3'b001);
    check("basic_valid", 32'(valid8), 32'd1);
    check("basic_count", 32'(count8), 32'h000205);
    check("basic_winner", 32'(win8), 32'd0);
    check("basic_wv", 32'(wv8), WTA ? 32'd1 : 32'd0);
    check("basic_ovf", 32'(ovf8), 32'd0);
    tick(0, 0, 8'd0, 3'b000);

    // Enable gating: 4 enabled samples over 7 busy cycles
    tick(1, 1, 8'd4, 3'b010);
    v = 0;
    for (int i = 0; i < 7; i++) begin
      if (busy8) v++;
      tick(((i % 2) == 0), 0, 8'd4, 3'b010);
    end
    check("gate_busy_cycles", 32'(v), 32'd7);
    check("gate_valid", 32'(valid8), 32'd1);
    check("gate_count", 32'(count8), 32'h000400);
    check("gate_winner", 32'(win8), WTA ? 32'd1 : 32'd0);
    tick(0, 0, 8'd0, 3'b000);

    // Exactly-max window: 255 on ch0/ch1, tie, no overflow at CNT_W=8
    tick(1, 1, 8'd255, 3'b011);
    repeat (255) tick(1, 0, 8'd0, 3'b011);
    check("sat_count8", 32'(count8), 32'h00FFFF);
    check("sat_ovf8", 32'(ovf8), 32'd0);
    check("sat_tie_winner", 32'(win8), 32'd0);
    check("sat_ovf4", 32'(ovf4), 32'd1);
    tick(0, 0, 8'd0, 3'b000);

    // 20-cycle window saturates the 4-bit counters
    tick(1, 1, 8'd20, 3'b011);
    repeat (20) tick(1, 0, 8'd0, 3'b011);
    check("sat20_count4", 32'(count4), 32'h0FF);
    check("sat20_ovf4", 32'(ovf4), 32'd1);
    check("sat20_count8", 32'(count8), 32'h001414);
    check("sat20_ovf8", 32'(ovf8), 32'd0);
    tick(0, 0, 8'd0, 3'b000);

    // Back-to-back windows of 3: report every 4 cycles
    v = 0;
    repeat (16) begin
      tick(1, 1, 8'd3, 3'($urandom));
      if (valid8) v++;
    end
    check("b2b_reports", 32'(v), 32'd4);
    tick(0, 0, 8'd0, 3'b000);
    tick(0, 0, 8'd0, 3'b000);

    // Zero length start is ignored
    v = 0;
    repeat (5) begin
      tick(1, 1, 8'd0, 3'b111);
      if (busy8 || valid8) v++;
    end
    check("zero_len_idle", 32'(v), 32'd0);

    // All-zero window
    tick(1, 1, 8'd6, 3'b000);
    repeat (6) tick(1, 0, 8'd6, 3'b000);
    check("zero_valid", 32'(valid8), 32'd1);
    check("zero_count", 32'(count8), 32'd0);
    check("zero_winner", 32'(win8), 32'd0);
    check("zero_wv", 32'(wv8), 32'd0);
    tick(0, 0, 8'd0, 3'b000);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      tick(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 12)), 3'($urandom));
    end
    tick(0, 0, 8'd0, 3'b000);
    tick(0, 0, 8'd0, 3'b000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
